ar_arbiter: RTL and testbench

Sequencer and arbiter for the 16-bit address register (AR): up to `N_REQ` requesters (instruction fetch, operand fetch, stack, DMA) compete for AR and the memory strobe. The block selects one requester, drives AR's `en`/`in`, and issues a read or write strobe once AR holds the address. It holds the grant until memory acknowledges or a watchdog expires, then pulses completion. It sits between the control unit / DMA and the AR plus memory interface.

---
 rtl/ar_arb_pkg.sv | 19 +
 rtl/ar_arb_pick.sv | 38 +++
 rtl/ar_arbiter.sv | 147 ++++++++++++++
 tb/tb_ar_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ar_arb_pkg.sv
// Shared types and default sizing for the AR sequencer/arbiter.
package ar_arb_pkg;

  localparam int AR_ARB_N_REQ    = 4;
  localparam int AR_ARB_AW       = 16;
  localparam int AR_ARB_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } ar_arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ar_arb_pick.sv
// Combinational requester picker: first active request found scanning
// upward from the start pointer, wrapping at N_REQ.
module ar_arb_pick
  import ar_arb_pkg::*;
#(
  parameter  int N_REQ = AR_ARB_N_REQ,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_vld
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // NOTE: every output gets a default before the loop, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && req[wrap_idx(ptr, k)]) begin
        win_vld                  = 1'b1;
        win_oh[wrap_idx(ptr, k)] = 1'b1;
        win_idx                  = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// AR load / memory strobe sequencer with requester arbitration and watchdog.
// Define AR_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module ar_arbiter
  import ar_arb_pkg::*;
#(
  parameter int N_REQ    = AR_ARB_N_REQ,
  parameter int AW       = AR_ARB_AW,
  parameter int MAX_WAIT = AR_ARB_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ-1:0]    req_wr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic                ar_en,
  output logic [AW-1:0]       ar_d,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic                mem_ack,
  output logic                busy
);

  localparam int         IW       = idx_width(N_REQ);
  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  ar_arb_state_t state_q, state_d;
  logic [IW-1:0] w_q;
  logic          wr_q;
  logic          abort_q;
  logic [7:0]    cnt_q;

  logic [IW-1:0]    pick_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             wr_sel;
  logic [N_REQ-1:0] w_oh;

`ifdef AR_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;

  // Pointer moves past the requester just served, aborted or not.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q <= '0;
    end else if (state_q == RELEASE) begin
      ptr_q <= (w_q == IW'(N_REQ - 1)) ? '0 : w_q + IW'(1);
    end
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  ar_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign wr_sel = |(pick_oh & req_wr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = LOAD;
      LOAD:    state_d = ACCESS;
      ACCESS:  if (mem_ack || cnt_q == CNT_LAST) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      w_q     <= '0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            w_q  <= pick_idx;
            wr_q <= wr_sel;
          end
        end
        LOAD: cnt_q <= '0;
        ACCESS: begin
          if (!mem_ack) begin
            if (cnt_q == CNT_LAST) abort_q <= 1'b1;
            else                   cnt_q   <= cnt_q + 8'd1;
          end
        end
        RELEASE: begin
          w_q     <= '0;
          abort_q <= 1'b0;
          cnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_oh = N_REQ'(1) << w_q;

  // Outputs decode registered state only; ar_d forwards the winner's address.
  always_comb begin
    gnt    = '0;
    done   = '0;
    err    = 1'b0;
    ar_en  = 1'b0;
    ar_d   = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        gnt   = w_oh;
        ar_en = 1'b1;
        ar_d  = req_addr[int'(w_q)*AW +: AW];
      end
      ACCESS: begin
        gnt    = w_oh;
        mem_rd = !wr_q;
        mem_wr = wr_q;
      end
      RELEASE: begin
        gnt  = w_oh;
        done = w_oh;
        err  = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ar_arbiter.sv
// Directed self-checking bench for ar_arbiter (default sizing).
module tb_ar_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int MW = 15;

  logic          clk;
  logic          rst_b;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_wr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic          err;
  logic          ar_en;
  logic [AW-1:0] ar_d;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ack;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  ar_arbiter #(.N_REQ(N), .AW(AW), .MAX_WAIT(MW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req      (req),
    .req_addr (req_addr),
    .req_wr   (req_wr),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .ar_en    (ar_en),
    .ar_d     (ar_d),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b000, gnt, done, err, ar_en, ar_d, mem_rd, mem_wr, busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_b   = 1'b0;
    req     = '0;
    mem_ack = 1'b0;
    #1;
    check("rst_outs", outs(), 32'h0);
    step();
    rst_b = 1'b1;
  endtask

  // Starts in an IDLE cycle with req already driven; ends in the following IDLE cycle.
  task automatic run_txn(input string tag, input int idx, input logic wr_exp,
                         input logic [AW-1:0] a_exp, input int ack_cycle,
                         input logic err_exp, input bit drop, input logic [N-1:0] req_after);
    logic [N-1:0] oh;
    int acc;
    int bad;
    bit fin;
    int exp_acc;
    oh      = N'(1) << idx;
    exp_acc = (ack_cycle > 0) ? ack_cycle : MW;
    acc     = 0;
    bad     = 0;
    fin     = 1'b0;

    step();
    check({tag, "_load"}, {5'b0, gnt, ar_en, ar_d, mem_rd, mem_wr, done},
          {5'b0, oh, 1'b1, a_exp, 2'b00, 4'b0000});
    if (drop) req = '0;
    mem_ack = (ack_cycle == 0) ? 1'b0 : 1'b0;

    for (int k = 0; k < 300 && !fin; k++) begin
      step();
      if (done !== '0 || busy !== 1'b1) begin
        fin = 1'b1;
      end else begin
        acc++;
        if ({gnt, ar_en, ar_d, mem_rd, mem_wr, err} !== {oh, 1'b0, 16'h0000, ~wr_exp, wr_exp, 1'b0})
          bad++;
        mem_ack = (acc == ack_cycle);
      end
    end
    mem_ack = 1'b0;

    check({tag, "_ended"}, 32'(fin), 32'd1);
    check({tag, "_access_cycles"}, 32'(acc), 32'(exp_acc));
    check({tag, "_access_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, "_release"}, {19'b0, gnt, done, err, ar_en, mem_rd, mem_wr, busy},
          {19'b0, oh, oh, err_exp, 3'b000, 1'b1});
    req = req_after;

    step();
    check({tag, "_idle"}, outs(), 32'h0);
  endtask

  initial begin
    int exp_idx;
    rst_b    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_wr   = '0;
    mem_ack  = 1'b0;

    do_reset();

    // ack while idle and no request must not start anything
    mem_ack = 1'b1;
    step();
    check("ack_in_idle", outs(), 32'h0);
    mem_ack = 1'b0;

    set_addr(1, 16'h1234);
    req_wr = 4'b0000;
    req    = 4'b0010;
    run_txn("single_read", 1, 1'b0, 16'h1234, 1, 1'b0, 1'b0, 4'b0000);

    set_addr(0, 16'hBEEF);
    req_wr = 4'b0001;
    req    = 4'b0001;
    run_txn("wait_states", 0, 1'b1, 16'hBEEF, 4, 1'b0, 1'b0, 4'b0000);

    set_addr(2, 16'h0F0F);
    req_wr = 4'b0000;
    req    = 4'b0100;
    run_txn("watchdog", 2, 1'b0, 16'h0F0F, 0, 1'b1, 1'b0, 4'b0000);

    set_addr(3, 16'h3333);
    req_wr = 4'b1000;
    req    = 4'b1000;
    run_txn("req_dropped", 3, 1'b1, 16'h3333, 2, 1'b0, 1'b1, 4'b0000);

    // reset asserted mid-ACCESS
    set_addr(0, 16'hA5A5);
    req_wr = 4'b0000;
    req    = 4'b0001;
    step();
    step();
    check("pre_rst_access", {30'b0, mem_rd, busy}, {30'b0, 2'b11});
    #2;
    rst_b = 1'b0;
    #1;
    check("rst_async_outs", outs(), 32'h0);
    step();
    check("rst_held_outs", outs(), 32'h0);
    rst_b = 1'b1;
    run_txn("restart", 0, 1'b0, 16'hA5A5, 1, 1'b0, 1'b0, 4'b0000);

    // contention with all requests held
    do_reset();
    set_addr(0, 16'hA000);
    set_addr(1, 16'hB111);
    set_addr(2, 16'hC222);
    set_addr(3, 16'hD333);
    req_wr = 4'b1010;
    req    = 4'b1111;
    for (int t = 0; t < 5; t++) begin
`ifdef AR_ARB_ROUND_ROBIN_EN
      exp_idx = t % N;
`else
      exp_idx = 0;
`endif
      run_txn($sformatf("contend%0d", t), exp_idx, req_wr[exp_idx],
              req_addr[exp_idx*AW +: AW], 1, 1'b0, 1'b0, (t == 4) ? 4'b0000 : 4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
